// File: rtl/avgpool_pkg.sv
// Shared types and elaboration-time sizing helpers for the average-pooling stream controller.
package avgpool_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StAccum,
    StEmit
  } state_e;

  function automatic int out_dim(int in_dim, int k, int stride);
    return (in_dim - k) / stride + 1;
  endfunction

  function automatic int acc_width(int width, int k);
    return width + $clog2(k * k) + 1;
  endfunction

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avgpool_round.sv
// Divides a window sum by K*K, rounding half away from zero, and truncates to WIDTH bits.
module avgpool_round #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 19,
  parameter int K         = 2
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [WIDTH-1:0]     rounded
);

  localparam int D = K * K;

  logic                 neg;
  logic [ACC_WIDTH-1:0] mag;
  logic [ACC_WIDTH-1:0] quo;

  always_comb begin
    neg     = sum[ACC_WIDTH-1];
    mag     = neg ? ACC_WIDTH'(-sum) : ACC_WIDTH'(sum);
    quo     = (mag + ACC_WIDTH'(D / 2)) / ACC_WIDTH'(D);
    rounded = WIDTH'(neg ? -quo : quo);
  end

endmodule

// File: rtl/avgpool_stream_ctrl.sv
// Streaming average pool: buffers one full frame, then walks each KxK window one element
// per cycle and hands out one rounded average per output handshake.
module avgpool_stream_ctrl
  import avgpool_pkg::*;
#(
  parameter int CH     = 1,
  parameter int IN_H   = 4,
  parameter int IN_W   = 4,
  parameter int K      = 2,
  parameter int STRIDE = 2,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  if (K < 1 || STRIDE < 1 || K > IN_H || K > IN_W) begin : gen_bad_params
    $fatal(1, "avgpool_stream_ctrl: K/STRIDE illegal for the input size");
  end

  localparam int OUT_H     = out_dim(IN_H, K, STRIDE);
  localparam int OUT_W     = out_dim(IN_W, K, STRIDE);
  localparam int ACC_WIDTH = acc_width(WIDTH, K);
  localparam int NELEM     = CH * IN_H * IN_W;
  localparam int AW        = cnt_width(NELEM);
  localparam int CW        = cnt_width(CH);
  localparam int HW        = cnt_width(OUT_H);
  localparam int WW        = cnt_width(OUT_W);
  localparam int KCW       = cnt_width(K);

  state_e                       state_q, state_d;
  logic [AW-1:0]                load_q, load_d;
  logic [CW-1:0]                c_q, c_d;
  logic [HW-1:0]                oh_q, oh_d;
  logic [WW-1:0]                ow_q, ow_d;
  logic [KCW-1:0]               kh_q, kh_d;
  logic [KCW-1:0]               kw_q, kw_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]             out_data_q, out_data_d;
  logic                         out_last_q, out_last_d;

  logic [WIDTH-1:0]             mem [NELEM];
  int                           row, col, rd_idx;
  logic signed [WIDTH-1:0]      elem;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic [WIDTH-1:0]             rounded;
  logic                         first_tap, last_out;

  // Channel-major raster address of the current window tap.
  always_comb begin
    row     = int'(oh_q) * STRIDE + int'(kh_q);
    col     = int'(ow_q) * STRIDE + int'(kw_q);
    rd_idx  = (int'(c_q) * IN_H + row) * IN_W + col;
    elem    = mem[AW'(rd_idx)];
    first_tap = (kh_q == '0) && (kw_q == '0);
    acc_sum = (first_tap ? '0 : acc_q) + ACC_WIDTH'(elem);
    last_out = (c_q == CW'(CH - 1)) && (oh_q == HW'(OUT_H - 1)) && (ow_q == WW'(OUT_W - 1));
  end

  avgpool_round #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .K        (K)
  ) u_round (
    .sum    (acc_sum),
    .rounded(rounded)
  );

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    c_d        = c_q;
    oh_d       = oh_q;
    ow_d       = ow_q;
    kh_d       = kh_q;
    kw_d       = kw_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          if (load_q == AW'(NELEM - 1)) begin
            load_d  = '0;
            c_d     = '0;
            oh_d    = '0;
            ow_d    = '0;
            kh_d    = '0;
            kw_d    = '0;
            state_d = StAccum;
          end else begin
            load_d = load_q + AW'(1);
          end
        end
      end
      StAccum: begin
        acc_d = acc_sum;
        if (kw_q == KCW'(K - 1)) begin
          kw_d = '0;
          if (kh_q == KCW'(K - 1)) begin
            kh_d       = '0;
            out_data_d = rounded;
            out_last_d = last_out;
            state_d    = StEmit;
          end else begin
            kh_d = kh_q + KCW'(1);
          end
        end else begin
          kw_d = kw_q + KCW'(1);
        end
      end
      StEmit: begin
        if (out_ready) begin
          state_d = StAccum;
          if (ow_q == WW'(OUT_W - 1)) begin
            ow_d = '0;
            if (oh_q == HW'(OUT_H - 1)) begin
              oh_d = '0;
              if (c_q == CW'(CH - 1)) begin
                c_d     = '0;
                state_d = StLoad;
              end else begin
                c_d = c_q + CW'(1);
              end
            end else begin
              oh_d = oh_q + HW'(1);
            end
          end else begin
            ow_d = ow_q + WW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      load_q     <= '0;
      c_q        <= '0;
      oh_q       <= '0;
      ow_q       <= '0;
      kh_q       <= '0;
      kw_q       <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      c_q        <= c_d;
      oh_q       <= oh_d;
      ow_q       <= ow_d;
      kh_q       <= kh_d;
      kw_q       <= kw_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  // Frame buffer is fully rewritten before any read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid && (state_q == StLoad)) begin
      mem[load_q] <= in_data;
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StEmit);
  assign busy      = (state_q != StLoad);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_avgpool_stream_ctrl.sv
// Self-checking bench: four pooling configurations driven with directed and random frames.
module tb_avgpool_stream_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [15:0] in_data   [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [15:0] out_data  [N];
  logic        out_last  [N];
  logic        busy      [N];

  int cfg_ch [N] = '{1, 1, 2, 1};
  int cfg_h  [N] = '{2, 4, 2, 5};
  int cfg_w  [N] = '{2, 4, 2, 4};
  int cfg_k  [N] = '{2, 2, 2, 3};
  int cfg_s  [N] = '{2, 2, 2, 1};

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_data [$];
  logic        exp_last [$];

  always #5 clk = ~clk;

  avgpool_stream_ctrl #(.CH(1), .IN_H(2), .IN_W(2), .K(2), .STRIDE(2), .WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0])
  );

  avgpool_stream_ctrl #(.CH(1), .IN_H(4), .IN_W(4), .K(2), .STRIDE(2), .WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1])
  );

  avgpool_stream_ctrl #(.CH(2), .IN_H(2), .IN_W(2), .K(2), .STRIDE(2), .WIDTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_last(out_last[2]), .busy(busy[2])
  );

  avgpool_stream_ctrl #(.CH(1), .IN_H(5), .IN_W(4), .K(3), .STRIDE(1), .WIDTH(16)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(out_data[3]), .out_last(out_last[3]), .busy(busy[3])
  );

  // Reference: average of every window, rounded half away from zero; last = final output.
  task automatic model(input int d, input int vals[$]);
    int oh_n, ow_n, total, idx, sum, dd, mag, q, r, p;
    logic signed [15:0] e;
    oh_n  = (cfg_h[d] - cfg_k[d]) / cfg_s[d] + 1;
    ow_n  = (cfg_w[d] - cfg_k[d]) / cfg_s[d] + 1;
    total = cfg_ch[d] * oh_n * ow_n;
    dd    = cfg_k[d] * cfg_k[d];
    idx   = 0;
    for (int c = 0; c < cfg_ch[d]; c++) begin
      for (int y = 0; y < oh_n; y++) begin
        for (int x = 0; x < ow_n; x++) begin
          sum = 0;
          for (int i = 0; i < cfg_k[d]; i++) begin
            for (int j = 0; j < cfg_k[d]; j++) begin
              p   = (c * cfg_h[d] + y * cfg_s[d] + i) * cfg_w[d] + x * cfg_s[d] + j;
              e   = vals[p][15:0];
              sum = sum + e;
            end
          end
          mag = (sum < 0) ? -sum : sum;
          q   = (mag + dd / 2) / dd;
          r   = (sum < 0) ? -q : q;
          exp_data.push_back(r[15:0]);
          exp_last.push_back(idx == total - 1);
          idx++;
        end
      end
    end
  endtask

  task automatic send_frame(input int d, input int vals[$]);
    foreach (vals[i]) begin
      @(negedge clk);
      tests++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
        fails++;
        $display("FAIL load_ready d%0d elem %0d: in_ready=%b out_valid=%b, required 1 and 0",
                 d, i, in_ready[d], out_valid[d]);
      end
      in_valid[d] = 1'b1;
      in_data[d]  = vals[i][15:0];
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // Drains exp_data from instance d; junk on in_valid/out_ready while no output is offered.
  task automatic collect(input int d, input int stall_min, input int stall_max);
    int          kk, cyc, stall;
    logic [15:0] ed;
    logic        el;
    kk = cfg_k[d] * cfg_k[d];
    while (exp_data.size() > 0) begin
      ed  = exp_data.pop_front();
      el  = exp_last.pop_front();
      cyc = 0;
      while (out_valid[d] !== 1'b1 && cyc < 200) begin
        in_valid[d]  = 1'($urandom_range(0, 1));
        in_data[d]   = 16'($urandom);
        out_ready[d] = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
      if (out_valid[d] !== 1'b1) begin
        tests++;
        fails++;
        $display("FAIL out_timeout d%0d: out_valid=%b after %0d cycles, required 1", d,
                 out_valid[d], cyc);
        exp_data.delete();
        exp_last.delete();
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        return;
      end
      tests++;
      if (cyc != kk) begin
        fails++;
        $display("FAIL latency d%0d: %0d cycles, required %0d", d, cyc, kk);
      end
      tests++;
      if (out_data[d] !== ed) begin
        fails++;
        $display("FAIL out_data d%0d: got %0d, required %0d", d, $signed(out_data[d]),
                 $signed(ed));
      end
      tests++;
      if (out_last[d] !== el) begin
        fails++;
        $display("FAIL out_last d%0d: got %b, required %b", d, out_last[d], el);
      end
      stall = $urandom_range(stall_max, stall_min);
      for (int j = 0; j < stall; j++) begin
        out_ready[d] = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid[d] !== 1'b1 || out_data[d] !== ed || out_last[d] !== el ||
            in_ready[d] !== 1'b0) begin
          fails++;
          $display("FAIL emit_hold d%0d: valid=%b data=%0d last=%b in_ready=%b, required 1 %0d %b 0",
                   d, out_valid[d], $signed(out_data[d]), out_last[d], in_ready[d],
                   $signed(ed), el);
        end
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      tests++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
          out_data[d] !== 16'h0 || out_last[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state d%0d: ready=%b valid=%b busy=%b data=%h last=%b, required 1 0 0 0000 0",
                 d, in_ready[d], out_valid[d], busy[d], out_data[d], out_last[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_small_2x2();
    int vals[$];
    vals = '{1, 2, 3, 4};
    exp_data.push_back(16'd3); exp_last.push_back(1'b1);
    send_frame(0, vals); collect(0, 0, 0);
    vals = '{-1, -2, -3, -4};
    exp_data.push_back(16'(-3)); exp_last.push_back(1'b1);
    send_frame(0, vals); collect(0, 0, 0);
    vals = '{1, 1, 0, 0};
    exp_data.push_back(16'd1); exp_last.push_back(1'b1);
    send_frame(0, vals); collect(0, 0, 0);
    vals = '{-1, -1, 0, 0};
    exp_data.push_back(16'(-1)); exp_last.push_back(1'b1);
    send_frame(0, vals); collect(0, 0, 0);
  endtask

  task automatic test_frame_4x4();
    int vals[$];
    for (int i = 0; i < 16; i++) vals.push_back(i);
    exp_data = '{16'd3, 16'd5, 16'd11, 16'd13};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_frame(1, vals);
    collect(1, 0, 2);
  endtask

  task automatic test_emit_stall();
    int vals[$];
    for (int i = 0; i < 16; i++) vals.push_back(int'($urandom_range(0, 65535)) - 32768);
    model(1, vals);
    send_frame(1, vals);
    collect(1, 5, 5);
  endtask

  task automatic test_reset_mid_frame();
    int vals[$];
    int cyc;
    for (int i = 0; i < 16; i++) vals.push_back(i);
    send_frame(1, vals);
    cyc = 0;
    while (out_valid[1] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: valid=%b in_ready=%b busy=%b, required 0 1 0",
               out_valid[1], in_ready[1], busy[1]);
    end
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(4);
    exp_data = '{16'd4, 16'd4, 16'd4, 16'd4};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_frame(1, vals);
    collect(1, 0, 1);
    vals = '{4, 4, 4, 4};
    exp_data.push_back(16'd4); exp_last.push_back(1'b1);
    send_frame(0, vals);
    collect(0, 0, 0);
  endtask

  task automatic test_two_channel();
    int vals[$];
    vals = '{1, 2, 3, 4, 5, 6, 7, 8};
    exp_data = '{16'd3, 16'd7};
    exp_last = '{1'b0, 1'b1};
    send_frame(2, vals);
    collect(2, 0, 1);
  endtask

  task automatic test_back_to_back();
    int vals[$];
    int n;
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < N; d++) begin
        vals.delete();
        n = cfg_ch[d] * cfg_h[d] * cfg_w[d];
        for (int i = 0; i < n; i++) begin
          if (f == 0) vals.push_back(int'($urandom_range(0, 16)) - 8);
          else        vals.push_back(int'($urandom_range(0, 65535)) - 32768);
        end
        model(d, vals);
        send_frame(d, vals);
        collect(d, 0, 3);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = 16'h0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_small_2x2();
    test_frame_4x4();
    test_emit_stall();
    test_reset_mid_frame();
    test_two_channel();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
